// File: rtl/game_state_ctrl.sv
// game_state_ctrl: game-flow sequencer for the plane game.
// It runs the IDLE/PLAY/HIT/OVER flow, counts frames from the HDMI
// field sync into a four-digit BCD score, tracks lives and drives the
// freeze and blink controls used by the sprite logic.
// Optional feature: define GAME_HISCORE_EN to keep a best-score register
// that updates on entry to OVER. Without it, hiscore is tied to zero.
module game_state_ctrl #(
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned SCORE_FRAMES  = 60,
  parameter int unsigned INVULN_FRAMES = 120
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        RGB_VSync,
  input  logic        CRASH,
  input  logic        key1,
  input  logic        key2,
  output logic [1:0]  game_state,
  output logic        freeze,
  output logic        blink,
  output logic [15:0] score,
  output logic [1:0]  lives,
  output logic [15:0] hiscore
);

  // state     | meaning
  // ST_IDLE   | attract screen, motion frozen, waiting for a key press
  // ST_PLAY   | game running, score ticking, a crash costs one life
  // ST_HIT    | invulnerable after a crash, sprite blinks, score ticking
  // ST_OVER   | no lives left, score and lives frozen, press returns to IDLE
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_HIT  = 2'b10,
    ST_OVER = 2'b11
  } state_t;

  localparam logic [1:0] LIVES_LD   = 2'(LIVES_INIT);
  localparam logic [7:0] SCORE_LAST = 8'(SCORE_FRAMES - 1);
  localparam logic [7:0] INV_LAST   = 8'(INVULN_FRAMES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  frame_cnt;
  logic [7:0]  frame_cnt_nxt;
  logic [7:0]  inv_cnt;
  logic [7:0]  inv_cnt_nxt;
  logic [15:0] score_nxt;
  logic [1:0]  lives_nxt;

  logic        vs_meta;
  logic        vs_sync;
  logic        vs_prev;
  logic        frame_tick;

  logic        key_any;
  logic        key_prev;
  logic        key_armed;
  logic        press;

  // Four-digit BCD increment with per-digit carry; 9999 is a ceiling.
  function automatic logic [15:0] bcd_inc(input logic [15:0] val);
    logic [15:0] res;
    logic        carry;
    res   = val;
    carry = 1'b1;
    if (val != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (res[i*4 +: 4] == 4'd9) begin
            res[i*4 +: 4] = 4'd0;
          end else begin
            res[i*4 +: 4] = res[i*4 +: 4] + 4'd1;
            carry         = 1'b0;
          end
        end
      end
    end
    return res;
  endfunction

  // Field sync crosses into clk through two flops; a third flop gives the
  // previous level so the rising edge becomes a registered one-cycle tick.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      vs_meta    <= 1'b0;
      vs_sync    <= 1'b0;
      vs_prev    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vs_meta    <= RGB_VSync;
      vs_sync    <= vs_meta;
      vs_prev    <= vs_sync;
      frame_tick <= vs_sync & ~vs_prev;
    end
  end

  assign key_any = key1 | key2;
  // A press needs the keys to have been seen released since reset, so a
  // button held through reset release cannot start a game on its own.
  assign press   = key_any & ~key_prev & key_armed;

  // Key edge detector: previous level plus the released-since-reset flag.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      key_prev  <= 1'b0;
      key_armed <= 1'b0;
    end else begin
      key_prev <= key_any;
      if (!key_any) begin
        key_armed <= 1'b1;
      end
    end
  end

  // Next-state, counter and score logic for the game flow.
  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    inv_cnt_nxt   = inv_cnt;
    score_nxt     = score;
    lives_nxt     = lives;
    case (state)
      ST_IDLE: begin
        if (press) begin
          state_nxt     = ST_PLAY;
          score_nxt     = 16'h0000;
          lives_nxt     = LIVES_LD;
          frame_cnt_nxt = 8'd0;
        end
      end
      ST_PLAY, ST_HIT: begin
        if (frame_tick) begin
          if (frame_cnt == SCORE_LAST) begin
            frame_cnt_nxt = 8'd0;
            score_nxt     = bcd_inc(score);
          end else begin
            frame_cnt_nxt = frame_cnt + 8'd1;
          end
        end
        if (state == ST_PLAY) begin
          if (CRASH) begin
            lives_nxt = lives - 2'd1;
            if (lives == 2'd1) begin
              state_nxt = ST_OVER;
            end else begin
              state_nxt   = ST_HIT;
              inv_cnt_nxt = 8'd0;
            end
          end
        end else if (frame_tick) begin
          if (inv_cnt == INV_LAST) begin
            state_nxt   = ST_PLAY;
            inv_cnt_nxt = 8'd0;
          end else begin
            inv_cnt_nxt = inv_cnt + 8'd1;
          end
        end
      end
      ST_OVER: begin
        if (press) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; freeze and blink are derived
  // from the next state so they line up with game_state.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state     <= ST_IDLE;
      frame_cnt <= 8'd0;
      inv_cnt   <= 8'd0;
      score     <= 16'h0000;
      lives     <= LIVES_LD;
      freeze    <= 1'b1;
      blink     <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_cnt <= frame_cnt_nxt;
      inv_cnt   <= inv_cnt_nxt;
      score     <= score_nxt;
      lives     <= lives_nxt;
      freeze    <= (state_nxt == ST_IDLE) || (state_nxt == ST_OVER);
      blink     <= (state_nxt == ST_HIT) && inv_cnt_nxt[3];
    end
  end

  assign game_state = state;

`ifdef GAME_HISCORE_EN
  // Best score captured on entry to OVER; packed BCD orders like binary,
  // so a plain unsigned compare is a correct BCD compare.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      hiscore <= 16'h0000;
    end else if ((state_nxt == ST_OVER) && (state != ST_OVER) &&
                 (score_nxt > hiscore)) begin
      hiscore <= score_nxt;
    end
  end
`else
  assign hiscore = 16'h0000;
`endif

endmodule
